// File: rtl/alu_exec_unit.sv
// ALU execute unit: ALUOp/func decode, single-cycle ALU ops and iterative multu/divu into HI/LO.
// Define ALU_EXEC_SIGNED_MULDIV_EN to add signed mult/div (func 011000 / 011010).
module alu_exec_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int FUNC_WIDTH  = 6,
   parameter int ALUOP_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ALUOP_WIDTH-1:0] alu_op,
   input  logic [FUNC_WIDTH-1:0]  func,
   input  logic [DATA_WIDTH-1:0]  src_a,
   input  logic [DATA_WIDTH-1:0]  src_b,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   zero,
   output logic                   illegal,
   output logic [DATA_WIDTH-1:0]  hi,
   output logic [DATA_WIDTH-1:0]  lo
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [ALUOP_WIDTH-1:0] OP_ADD = ALUOP_WIDTH'(0);
   localparam logic [ALUOP_WIDTH-1:0] OP_SUB = ALUOP_WIDTH'(1);
   localparam logic [ALUOP_WIDTH-1:0] OP_RTY = ALUOP_WIDTH'(2);

   localparam logic [FUNC_WIDTH-1:0] F_ADD   = FUNC_WIDTH'(6'b100000);
   localparam logic [FUNC_WIDTH-1:0] F_SUB   = FUNC_WIDTH'(6'b100010);
   localparam logic [FUNC_WIDTH-1:0] F_AND   = FUNC_WIDTH'(6'b100100);
   localparam logic [FUNC_WIDTH-1:0] F_OR    = FUNC_WIDTH'(6'b100101);
   localparam logic [FUNC_WIDTH-1:0] F_SLT   = FUNC_WIDTH'(6'b101010);
   localparam logic [FUNC_WIDTH-1:0] F_NOR   = FUNC_WIDTH'(6'b110000);
   localparam logic [FUNC_WIDTH-1:0] F_MFHI  = FUNC_WIDTH'(6'b010000);
   localparam logic [FUNC_WIDTH-1:0] F_MFLO  = FUNC_WIDTH'(6'b010010);
   localparam logic [FUNC_WIDTH-1:0] F_MULTU = FUNC_WIDTH'(6'b011001);
   localparam logic [FUNC_WIDTH-1:0] F_DIVU  = FUNC_WIDTH'(6'b011011);
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
   localparam logic [FUNC_WIDTH-1:0] F_MULT  = FUNC_WIDTH'(6'b011000);
   localparam logic [FUNC_WIDTH-1:0] F_DIV   = FUNC_WIDTH'(6'b011010);
`endif

   localparam logic [1:0] K_ALU = 2'd0;
   localparam logic [1:0] K_ILL = 2'd1;
   localparam logic [1:0] K_MUL = 2'd2;
   localparam logic [1:0] K_DIV = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

   state_t state_reg, state_next;

   logic [1:0]            dec_kind;
   logic [DATA_WIDTH-1:0] alu_val;
   logic [DATA_WIDTH-1:0] op_a, op_b;

   logic [DATA_WIDTH-1:0] acc_reg, q_reg, m_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  div_reg;

   logic [DATA_WIDTH-1:0] result_reg, hi_reg, lo_reg;
   logic                  zero_reg, illegal_reg, done_reg;

   logic [DATA_WIDTH:0]   mul_sum, div_sh;
   logic                  div_ge;
   logic [DATA_WIDTH-1:0] div_diff, acc_step, q_step;
   logic [DATA_WIDTH-1:0] hi_fin, lo_fin;

`ifdef ALU_EXEC_SIGNED_MULDIV_EN
   logic                  dec_signed;
   logic                  sgn_reg, neg_q_reg, neg_r_reg, b_zero_reg;
   logic [DATA_WIDTH-1:0] a_raw_reg;
   logic [2*DATA_WIDTH-1:0] prod;
`endif

   // Decode and single-cycle datapath; mfhi/mflo see HI/LO as registered now.
   always_comb begin
      dec_kind = K_ILL;
      alu_val  = '0;
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
      dec_signed = 1'b0;
`endif
      case (alu_op)
         OP_ADD: begin dec_kind = K_ALU; alu_val = src_a + src_b; end
         OP_SUB: begin dec_kind = K_ALU; alu_val = src_a - src_b; end
         OP_RTY: begin
            case (func)
               F_ADD:   begin dec_kind = K_ALU; alu_val = src_a + src_b; end
               F_SUB:   begin dec_kind = K_ALU; alu_val = src_a - src_b; end
               F_AND:   begin dec_kind = K_ALU; alu_val = src_a & src_b; end
               F_OR:    begin dec_kind = K_ALU; alu_val = src_a | src_b; end
               F_SLT:   begin
                  dec_kind = K_ALU;
                  alu_val  = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
               end
               F_NOR:   begin dec_kind = K_ALU; alu_val = ~(src_a | src_b); end
               F_MFHI:  begin dec_kind = K_ALU; alu_val = hi_reg; end
               F_MFLO:  begin dec_kind = K_ALU; alu_val = lo_reg; end
               F_MULTU: dec_kind = K_MUL;
               F_DIVU:  dec_kind = K_DIV;
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
               F_MULT:  begin dec_kind = K_MUL; dec_signed = 1'b1; end
               F_DIV:   begin dec_kind = K_DIV; dec_signed = 1'b1; end
`endif
               default: dec_kind = K_ILL;
            endcase
         end
         default: dec_kind = K_ILL;
      endcase
   end

`ifdef ALU_EXEC_SIGNED_MULDIV_EN
   assign op_a = (dec_signed && src_a[DATA_WIDTH-1]) ? -src_a : src_a;
   assign op_b = (dec_signed && src_b[DATA_WIDTH-1]) ? -src_b : src_b;
`else
   assign op_a = src_a;
   assign op_b = src_b;
`endif

   // acc/q double as {A,Q} for shift-add multiply and {R,Q} for restoring divide.
   always_comb begin
      mul_sum  = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
      div_sh   = {acc_reg, q_reg[DATA_WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, m_reg});
      div_diff = div_sh[DATA_WIDTH-1:0] - m_reg;
      if (div_reg) begin
         acc_step = div_ge ? div_diff : div_sh[DATA_WIDTH-1:0];
         q_step   = {q_reg[DATA_WIDTH-2:0], div_ge};
      end else begin
         acc_step = mul_sum[DATA_WIDTH:1];
         q_step   = {mul_sum[0], q_reg[DATA_WIDTH-1:1]};
      end
   end

   always_comb begin
      hi_fin = acc_reg;
      lo_fin = q_reg;
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
      prod = {acc_reg, q_reg};
      if (sgn_reg) begin
         if (div_reg) begin
            if (b_zero_reg) begin
               lo_fin = '1;
               hi_fin = a_raw_reg;
            end else begin
               lo_fin = neg_q_reg ? -q_reg : q_reg;
               hi_fin = neg_r_reg ? -acc_reg : acc_reg;
            end
         end else begin
            {hi_fin, lo_fin} = neg_q_reg ? -prod : prod;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start && (dec_kind == K_MUL || dec_kind == K_DIV)) state_next = S_ITER;
         S_ITER: if (cnt_reg == CNT_W'(DATA_WIDTH-1)) state_next = S_FIN;
         S_FIN:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_reg != S_IDLE);
      done    = done_reg;
      result  = result_reg;
      zero    = zero_reg;
      illegal = illegal_reg;
      hi      = hi_reg;
      lo      = lo_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg     <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         cnt_reg     <= '0;
         div_reg     <= 1'b0;
         result_reg  <= '0;
         zero_reg    <= 1'b1;
         illegal_reg <= 1'b0;
         done_reg    <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
         sgn_reg     <= 1'b0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         b_zero_reg  <= 1'b0;
         a_raw_reg   <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: if (start) begin
               case (dec_kind)
                  K_ALU: begin
                     result_reg  <= alu_val;
                     zero_reg    <= (alu_val == '0);
                     illegal_reg <= 1'b0;
                     done_reg    <= 1'b1;
                  end
                  K_ILL: begin
                     result_reg  <= '0;
                     zero_reg    <= 1'b1;
                     illegal_reg <= 1'b1;
                     done_reg    <= 1'b1;
                  end
                  default: begin
                     acc_reg <= '0;
                     cnt_reg <= '0;
                     div_reg <= (dec_kind == K_DIV);
                     q_reg   <= (dec_kind == K_DIV) ? op_a : op_b;
                     m_reg   <= (dec_kind == K_DIV) ? op_b : op_a;
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
                     sgn_reg    <= dec_signed;
                     neg_q_reg  <= src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1];
                     neg_r_reg  <= src_a[DATA_WIDTH-1];
                     b_zero_reg <= (src_b == '0);
                     a_raw_reg  <= src_a;
`endif
                  end
               endcase
            end
            S_ITER: begin
               acc_reg <= acc_step;
               q_reg   <= q_step;
               cnt_reg <= cnt_reg + 1'b1;
            end
            S_FIN: begin
               hi_reg      <= hi_fin;
               lo_reg      <= lo_fin;
               result_reg  <= lo_fin;
               zero_reg    <= (lo_fin == '0);
               illegal_reg <= 1'b0;
               done_reg    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at DATA_WIDTH=32; signed div vector only when
// ALU_EXEC_SIGNED_MULDIV_EN is defined.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  alu_op;
   logic [5:0]  func;
   logic [31:0] src_a, src_b;
   logic        busy, done, zero, illegal;
   logic [31:0] result, hi, lo;

   int errors = 0;
   int checks = 0;

   alu_exec_unit #(.DATA_WIDTH(32), .FUNC_WIDTH(6), .ALUOP_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .func(func),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
      .zero(zero), .illegal(illegal), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse; returns just after the edge that samples it.
   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; alu_op = op; func = fn; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      $display("issue op=%b func=%b a=%h b=%h -> done=%b busy=%b result=%h", op, fn, a, b, done, busy, result);
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!done && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_within_bound", done, 1'b1);
   endtask

   initial begin
      int n, cyc, busy_cnt, pulses;
      rst = 1'b1; start = 1'b0; alu_op = 2'b00; func = 6'd0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 32'h0);
      chk("rst_zero", zero, 1'b1);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clk); rst = 1'b0;

      issue(2'b10, 6'b100010, 32'd5, 32'd5);
      chk("sub_done", done, 1'b1);
      chk("sub_result", result, 32'h0);
      chk("sub_zero", zero, 1'b1);
      chk("sub_illegal", illegal, 1'b0);
      @(posedge clk); #1;
      chk("done_pulse_ends", done, 1'b0);
      chk("result_holds", result, 32'h0);

      issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
      chk("slt_result", result, 32'd1);
      chk("slt_zero", zero, 1'b0);
      issue(2'b10, 6'b110000, 32'h0, 32'h0);
      chk("nor_result", result, 32'hFFFF_FFFF);
      chk("nor_zero", zero, 1'b0);
      issue(2'b00, 6'b000000, 32'h7FFF_FFFF, 32'h8000_0003);
      chk("add_wrap", result, 32'h0000_0002);
      issue(2'b01, 6'b000000, 32'd3, 32'd5);
      chk("beq_sub_wrap", result, 32'hFFFF_FFFE);
      issue(2'b10, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F);
      chk("and_result", result, 32'h00F0_000F);
      issue(2'b10, 6'b100101, 32'hF000_0001, 32'h0000_0100);
      chk("or_result", result, 32'hF000_0101);

      // multu with start pulses injected while busy
      issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
      chk("multu_busy_after_start", busy, 1'b1);
      cyc = 1; busy_cnt = 0;
      while (!done && cyc < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         if (cyc == 5 || cyc == 20) begin
            start = 1'b1; alu_op = 2'b10;
            func  = (cyc == 5) ? 6'b100000 : 6'b011001;
            src_a = 32'd0; src_b = 32'd0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      $display("multu done at cycle %0d, busy cycles %0d, hi=%h lo=%h", cyc, busy_cnt, hi, lo);
      chk("multu_done", done, 1'b1);
      chk("multu_done_cycle", cyc, 34);
      chk("multu_busy_cycles", busy_cnt, 33);
      chk("multu_busy_low_at_done", busy, 1'b0);
      chk("multu_hi", hi, 32'd1);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      chk("multu_result", result, 32'hFFFF_FFFE);
      chk("multu_illegal", illegal, 1'b0);

      // issued in the cycle done is high
      issue(2'b10, 6'b010000, 32'h0, 32'h0);
      chk("mfhi_result", result, 32'd1);
      issue(2'b10, 6'b010010, 32'h0, 32'h0);
      chk("mflo_result", result, 32'hFFFF_FFFE);

      issue(2'b10, 6'b011011, 32'd100, 32'd7);
      wait_done(60, n);
      chk("divu_latency", n, 33);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("divu_result", result, 32'd14);

      issue(2'b10, 6'b011011, 32'd9, 32'd0);
      wait_done(60, n);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'd9);
      chk("div0_illegal", illegal, 1'b0);

      issue(2'b11, 6'b100000, 32'd1, 32'd1);
      chk("op11_done", done, 1'b1);
      chk("op11_illegal", illegal, 1'b1);
      chk("op11_result", result, 32'h0);
      chk("op11_zero", zero, 1'b1);
      chk("op11_hi", hi, 32'd9);
      chk("op11_lo", lo, 32'hFFFF_FFFF);
      issue(2'b10, 6'b000111, 32'd1, 32'd1);
      chk("badfunc_done", done, 1'b1);
      chk("badfunc_illegal", illegal, 1'b1);
      chk("badfunc_result", result, 32'h0);
      chk("badfunc_busy", busy, 1'b0);

`ifdef ALU_EXEC_SIGNED_MULDIV_EN
      issue(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
      wait_done(60, n);
      chk("div_signed_lo", lo, 32'hFFFF_FFFD);
      chk("div_signed_hi", hi, 32'hFFFF_FFFF);
      chk("div_signed_illegal", illegal, 1'b0);
      issue(2'b00, 6'b000000, 32'h0, 32'h0);
      issue(2'b10, 6'b011011, 32'd9, 32'd0);
      wait_done(60, n);
`else
      issue(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
      chk("div_disabled_illegal", illegal, 1'b1);
      chk("div_disabled_done", done, 1'b1);
      chk("div_disabled_hi", hi, 32'd9);
`endif

      issue(2'b00, 6'b000000, 32'd3, 32'd4);
      chk("add_clears_illegal", illegal, 1'b0);
      chk("add_result", result, 32'd7);

      // reset during a divide
      issue(2'b10, 6'b011011, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      chk("midrst_result", result, 32'h0);
      chk("midrst_zero", zero, 1'b1);
      chk("midrst_done", done, 1'b0);
      @(negedge clk); rst = 1'b0;
      issue(2'b00, 6'b000000, 32'd3, 32'd4);
      chk("postrst_add_done", done, 1'b1);
      chk("postrst_add_result", result, 32'd7);
      chk("postrst_busy", busy, 1'b0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("postrst_no_stale_done", pulses, 0);
      chk("postrst_lo_kept", lo, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
